// File: rtl/cache_lookup.sv
// cache_lookup: tag/state lookup stage for a 4-way MESIF cache with PLRU replacement,
// clear sweep and CPU hit/miss statistics.
module cache_lookup #(
  parameter int ADDR_BITS   = 32,
  parameter int INDEX_BITS  = 4,
  parameter int OFFSET_BITS = 6,
  parameter int CNT_BITS    = 32,
  localparam int TAG_BITS   = ADDR_BITS - INDEX_BITS - OFFSET_BITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [3:0]            req_op,
  input  logic [ADDR_BITS-1:0]  req_addr,
  output logic                  lk_valid,
  output logic [3:0]            lk_op,
  output logic [TAG_BITS-1:0]   lk_tag,
  output logic [INDEX_BITS-1:0] lk_index,
  output logic                  lk_hit,
  output logic [1:0]            lk_way,
  output logic [2:0]            lk_state,
  output logic [TAG_BITS-1:0]   lk_victim_tag,
  input  logic                  upd_valid,
  input  logic [2:0]            upd_state,
  output logic                  bad_op,
  output logic [CNT_BITS-1:0]   hit_count,
  output logic [CNT_BITS-1:0]   miss_count
);
  localparam int SETS = 1 << INDEX_BITS;
  localparam logic [2:0] ST_I = 3'd3;
  typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_WAIT, S_CLEAR} state_e;
  state_e st_q, st_d;
  logic [3:0]            op_q;
  logic [TAG_BITS-1:0]   tag_q;
  logic [INDEX_BITS-1:0] idx_q, clr_q;
  logic                  lk_valid_q, lk_hit_q, bad_op_q;
  logic [1:0]            lk_way_q;
  logic [2:0]            lk_state_q;
  logic [TAG_BITS-1:0]   lk_vtag_q;
  logic [CNT_BITS-1:0]   hit_q, miss_q;
  logic [TAG_BITS-1:0]   tags_q [SETS][4];
  logic [2:0]            mesi_q [SETS][4];
  logic [2:0]            plru_q [SETS];
  logic [3:0]            hv, iv;
  logic [1:0]            way_c;
  logic [2:0]            pl, pl_upd;
  logic                  accept, cpu, unused_off;
  assign unused_off = ^req_addr[OFFSET_BITS-1:0];
  assign req_ready  = st_q == S_IDLE;
  assign accept     = req_valid && req_ready;
  assign cpu        = op_q <= 4'd2;
  always_comb begin
    hv = '0;
    iv = '0;
    pl = plru_q[idx_q];
    for (int w = 0; w < 4; w++) begin
      iv[w] = mesi_q[idx_q][w] == ST_I;
      hv[w] = !iv[w] && tags_q[idx_q][w] == tag_q;
    end
    // hit way first, then snoop-miss way 0, then first invalid way, then PLRU victim
    way_c = hv[0] ? 2'd0 : hv[1] ? 2'd1 : hv[2] ? 2'd2 : hv[3] ? 2'd3 :
            !cpu  ? 2'd0 : iv[0] ? 2'd0 : iv[1] ? 2'd1 : iv[2] ? 2'd2 : iv[3] ? 2'd3 :
            pl[0] ? (pl[2] ? 2'd3 : 2'd2) : (pl[1] ? 2'd1 : 2'd0);
    pl_upd = !lk_way_q[1] ? {plru_q[idx_q][2], ~lk_way_q[0], 1'b1}
                          : {~lk_way_q[0], plru_q[idx_q][1], 1'b0};
  end
  always_comb begin
    st_d = st_q;
    if (st_q == S_IDLE && req_valid)
      st_d = req_op <= 4'd6 ? S_LOOKUP : req_op == 4'd8 ? S_CLEAR : S_IDLE;
    if (st_q == S_LOOKUP) st_d = S_WAIT;
    if (st_q == S_WAIT && upd_valid) st_d = S_IDLE;
    if (st_q == S_CLEAR && &clr_q) st_d = S_IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) st_q <= S_IDLE;
    else st_q <= st_d;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q       <= '0;
      tag_q      <= '0;
      idx_q      <= '0;
      clr_q      <= '0;
      lk_valid_q <= 1'b0;
      lk_hit_q   <= 1'b0;
      lk_way_q   <= '0;
      lk_state_q <= '0;
      lk_vtag_q  <= '0;
      bad_op_q   <= 1'b0;
      hit_q      <= '0;
      miss_q     <= '0;
      for (int s = 0; s < SETS; s++) begin
        plru_q[s] <= '0;
        for (int w = 0; w < 4; w++) begin
          tags_q[s][w] <= '0;
          mesi_q[s][w] <= ST_I;
        end
      end
    end else begin
      bad_op_q <= accept && (req_op == 4'd7 || req_op > 4'd9);
      if (accept && req_op <= 4'd6) begin
        op_q  <= req_op;
        tag_q <= req_addr[ADDR_BITS-1 -: TAG_BITS];
        idx_q <= req_addr[OFFSET_BITS +: INDEX_BITS];
      end
      if (st_q == S_LOOKUP) begin
        lk_valid_q <= 1'b1;
        lk_hit_q   <= |hv;
        lk_way_q   <= way_c;
        lk_state_q <= mesi_q[idx_q][way_c];
        lk_vtag_q  <= tags_q[idx_q][way_c];
      end
      if (st_q == S_WAIT && upd_valid) begin
        lk_valid_q <= 1'b0;
        if (cpu || lk_hit_q) mesi_q[idx_q][lk_way_q] <= upd_state;
        if (cpu) begin
          tags_q[idx_q][lk_way_q] <= tag_q;
          plru_q[idx_q]           <= pl_upd;
          if (lk_hit_q) hit_q <= hit_q + {{(CNT_BITS-1){1'b0}}, ~&hit_q};
          else miss_q <= miss_q + {{(CNT_BITS-1){1'b0}}, ~&miss_q};
        end
      end
      if (accept && req_op == 4'd8) begin
        clr_q  <= '0;
        hit_q  <= '0;
        miss_q <= '0;
      end
      if (st_q == S_CLEAR) begin
        clr_q         <= clr_q + INDEX_BITS'(1);
        plru_q[clr_q] <= '0;
        for (int w = 0; w < 4; w++) mesi_q[clr_q][w] <= ST_I;
      end
    end
  end
  assign lk_valid      = lk_valid_q;
  assign lk_op         = op_q;
  assign lk_tag        = tag_q;
  assign lk_index      = idx_q;
  assign lk_hit        = lk_hit_q;
  assign lk_way        = lk_way_q;
  assign lk_state      = lk_state_q;
  assign lk_victim_tag = lk_vtag_q;
  assign bad_op        = bad_op_q;
  assign hit_count     = hit_q;
  assign miss_count    = miss_q;
endmodule

// File: tb/tb_cache_lookup.sv
// tb_cache_lookup: directed checks of lookup, PLRU victim choice, snoop handling,
// clear sweep, async reset and bad-op reporting.
module tb_cache_lookup;
  logic        clk, rst, req_valid, req_ready, lk_valid, lk_hit, upd_valid, bad_op;
  logic [3:0]  req_op, lk_op;
  logic [31:0] req_addr, hit_count, miss_count;
  logic [21:0] lk_tag, lk_victim_tag;
  logic [3:0]  lk_index;
  logic [1:0]  lk_way;
  logic [2:0]  lk_state, upd_state;
  int tests = 0, fails = 0;

  cache_lookup dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .lk_valid(lk_valid), .lk_op(lk_op), .lk_tag(lk_tag),
    .lk_index(lk_index), .lk_hit(lk_hit), .lk_way(lk_way), .lk_state(lk_state),
    .lk_victim_tag(lk_victim_tag), .upd_valid(upd_valid), .upd_state(upd_state),
    .bad_op(bad_op), .hit_count(hit_count), .miss_count(miss_count)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // inputs driven and outputs sampled on the falling edge
  task automatic send(input logic [3:0] op, input logic [31:0] a);
    int n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    if (!req_ready) chk("ready_timeout", 0, 1);
    req_valid = 1; req_op = op; req_addr = a;
    @(negedge clk);
    req_valid = 0;
  endtask

  task automatic wait_lk();
    int n = 0;
    while (!lk_valid && n < 10) begin @(negedge clk); n++; end
    if (!lk_valid) chk("lk_valid_timeout", 0, 1);
  endtask

  task automatic update(input logic [2:0] s);
    upd_valid = 1; upd_state = s;
    @(negedge clk);
    upd_valid = 0;
    chk("lk_valid_fall", lk_valid, 0);
  endtask

  task automatic lookup(input string t, input logic [3:0] op, input logic [31:0] a,
                        input logic h, input logic [1:0] w, input logic [2:0] st);
    send(op, a);
    wait_lk();
    chk({t, "_hit"}, lk_hit, h);
    chk({t, "_way"}, lk_way, w);
    chk({t, "_state"}, lk_state, st);
  endtask

  initial begin
    int n;
    rst = 1; req_valid = 0; req_op = 0; req_addr = 0; upd_valid = 0; upd_state = 0;
    repeat (2) @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("rst_ready", req_ready, 1);
    chk("rst_lk_valid", lk_valid, 0);
    chk("rst_counts", {hit_count, miss_count}, 0);
    chk("rst_bad_op", bad_op, 0);
    chk("rst_lk_tag", lk_tag, 0);

    send(4'd0, 32'h0000_1040);
    chk("lat_lk_valid_early", lk_valid, 0);
    @(negedge clk);
    chk("lat_lk_valid", lk_valid, 1);
    chk("t1_tag", lk_tag, 22'h4);
    chk("t1_index", lk_index, 1);
    chk("t1_op", lk_op, 0);
    chk("t1_hit", lk_hit, 0);
    chk("t1_way", lk_way, 0);
    chk("t1_state", lk_state, 3);
    repeat (2) @(negedge clk);
    chk("t1_hold", {lk_valid, lk_way, lk_state}, {1'b1, 2'd0, 3'd3});
    update(3'd1);
    chk("t1_miss", miss_count, 1);
    chk("t1_ready_back", req_ready, 1);

    lookup("t2", 4'd0, 32'h1040, 1, 0, 1);
    update(3'd1);
    chk("t2_hit_cnt", hit_count, 1);

    lookup("f1", 4'd0, 32'h1440, 0, 1, 3); update(3'd1);
    lookup("f2", 4'd0, 32'h1840, 0, 2, 3); update(3'd1);
    lookup("f3", 4'd0, 32'h1C40, 0, 3, 3); update(3'd1);
    lookup("plru", 4'd1, 32'h2040, 0, 0, 1);
    chk("plru_vtag", lk_victim_tag, 22'h4);
    update(3'd0);
    chk("plru_miss", miss_count, 5);

    lookup("snp_miss", 4'd4, 32'h3040, 0, 0, 0);
    update(3'd2);
    chk("snp_counts", {hit_count, miss_count}, {32'd1, 32'd5});
    lookup("after_snp", 4'd0, 32'h3040, 0, 2, 1);
    chk("after_snp_vtag", lk_victim_tag, 22'h6);
    update(3'd1);

    lookup("snp_hit", 4'd3, 32'h2040, 1, 0, 0);
    update(3'd3);
    chk("snp_hit_counts", {hit_count, miss_count}, {32'd1, 32'd6});
    lookup("inv_reuse", 4'd0, 32'h4040, 0, 0, 3);
    update(3'd1);
    chk("inv_reuse_miss", miss_count, 7);

    upd_valid = 1; upd_state = 3'd0;
    repeat (2) @(negedge clk);
    upd_valid = 0;
    chk("stray_upd", {hit_count, miss_count, 31'd0, lk_valid}, {32'd1, 32'd7, 32'd0});
    send(4'd9, 32'h0);
    chk("print_noop", {req_ready, lk_valid, bad_op}, 3'b100);

    send(4'd8, 32'h0);
    n = 0;
    while (!req_ready && n < 40) begin n++; @(negedge clk); end
    chk("clear_len", n, 16);
    chk("clear_counts", {hit_count, miss_count}, 0);
    lookup("post_clr", 4'd0, 32'h1040, 0, 0, 3);
    update(3'd1);
    chk("post_clr_miss", miss_count, 1);

    send(4'd0, 32'h1080);
    wait_lk();
    rst = 1;
    #1;
    chk("async_rst_lk_valid", lk_valid, 0);
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("rst2_ready", req_ready, 1);
    chk("rst2_counts", {hit_count, miss_count}, 0);
    send(4'd7, 32'h0);
    chk("bad7_pulse", bad_op, 1);
    @(negedge clk);
    chk("bad7_clear", {bad_op, lk_valid}, 0);
    send(4'd12, 32'h0);
    chk("bad12_pulse", bad_op, 1);
    repeat (3) @(negedge clk);
    chk("bad12_idle", {bad_op, lk_valid, req_ready}, 3'b001);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
